// File: rtl/common_pkg.sv
// Shared scalar and register-address types used across the core.
package common;

    typedef logic       u1;
    typedef logic [4:0] creg_addr_t;

endpackage

// File: rtl/hazard_ctrl_pkg.sv
// Pipeline-control types: forwarding source select and mul/div sequencer state.
package pipes;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// Fixed-latency mul/div sequencer: holds EX while the unit runs and remembers
// that the op in EX has already finished so a later freeze cannot restart it.
module muldiv_seq
    import common::*;
    import pipes::*;
#(
    parameter int unsigned MULDIV_LAT = 16
) (
    input  logic clk,
    input  logic reset,
    input  u1    ex_valid,
    input  u1    ex_is_muldiv,
    input  u1    mem_stall,
    output u1    busy,
    output u1    done,
    output u1    hold
);

    localparam int unsigned CntW = $clog2(MULDIV_LAT + 1);

    hazard_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ex_done_q, ex_done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ex_done_d = ex_done_q;
        busy      = (state_q == BUSY);
        done      = busy && (cnt_q == CntW'(1));
        hold      = ex_valid & ex_is_muldiv & ~ex_done_q & ~done;

        unique case (state_q)
            IDLE: begin
                if (ex_valid && ex_is_muldiv && !ex_done_q) begin
                    state_d = BUSY;
                    cnt_d   = CntW'(MULDIV_LAT - 1);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = IDLE;
            end
        endcase

        // Leaving EX wins over setting, so a result taken immediately leaves no residue.
        if (done) ex_done_d = 1'b1;
        if (ex_valid && !(mem_stall || hold)) ex_done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ex_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_done_q <= ex_done_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use bubbles, mem-wait freeze
// and the mul/div hold (present only when HAZARD_MULDIV_EN is defined).
module hazard_ctrl
    import common::*;
    import pipes::*;
#(
    parameter int unsigned MULDIV_LAT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  u1          id_valid,
    input  u1          id_usea,
    input  u1          id_useb,
    input  creg_addr_t id_srca,
    input  creg_addr_t id_srcb,
    input  u1          ex_valid,
    input  u1          ex_wen,
    input  u1          ex_is_load,
    input  u1          ex_is_muldiv,
    input  creg_addr_t ex_dst,
    input  u1          mem_valid,
    input  u1          mem_wen,
    input  u1          mem_req,
    input  u1          mem_data_ok,
    input  creg_addr_t mem_dst,
    input  u1          wb_valid,
    input  u1          wb_wen,
    input  creg_addr_t wb_dst,
    output fwd_sel_t   fwd_sel_a,
    output fwd_sel_t   fwd_sel_b,
    output u1          stall_f,
    output u1          stall_d,
    output u1          stall_e,
    output u1          stall_m,
    output u1          bubble_e,
    output u1          bubble_w,
    output u1          muldiv_busy,
    output u1          muldiv_done
);

    function automatic fwd_sel_t pick_src(input creg_addr_t src, input u1 used,
                                          input u1 ex_fwd, input u1 mem_fwd, input u1 wb_fwd,
                                          input creg_addr_t exd, input creg_addr_t memd,
                                          input creg_addr_t wbd);
        pick_src = FWD_NONE;
        if (used && src != '0) begin
            if (ex_fwd && exd == src)        pick_src = FWD_EX;
            else if (mem_fwd && memd == src) pick_src = FWD_MEM;
            else if (wb_fwd && wbd == src)   pick_src = FWD_WB;
        end
    endfunction

    u1 mem_stall, md_hold, md_busy, md_done, load_use, ex_fwd, mem_fwd, wb_fwd, hold_e;

    assign mem_stall = mem_valid & mem_req & ~mem_data_ok;
    assign ex_fwd    = ex_valid & ex_wen & ~ex_is_load;
    assign mem_fwd   = mem_valid & mem_wen;
    assign wb_fwd    = wb_valid & wb_wen;
    assign load_use  = id_valid & ex_valid & ex_wen & ex_is_load & (ex_dst != '0) &
                       ((id_usea & (id_srca == ex_dst)) | (id_useb & (id_srcb == ex_dst)));

`ifdef HAZARD_MULDIV_EN
    muldiv_seq #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_seq (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_is_muldiv (ex_is_muldiv),
        .mem_stall    (mem_stall),
        .busy         (md_busy),
        .done         (md_done),
        .hold         (md_hold)
    );
`else
    logic unused_muldiv;
    assign unused_muldiv = ex_is_muldiv ^ clk;
    assign md_busy       = 1'b0;
    assign md_done       = 1'b0;
    assign md_hold       = 1'b0;
`endif

    assign hold_e = mem_stall | md_hold;

    always_comb begin
        fwd_sel_a   = FWD_NONE;
        fwd_sel_b   = FWD_NONE;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        bubble_e    = 1'b0;
        bubble_w    = 1'b0;
        muldiv_busy = 1'b0;
        muldiv_done = 1'b0;
        if (!reset) begin
            fwd_sel_a   = pick_src(id_srca, id_usea, ex_fwd, mem_fwd, wb_fwd,
                                   ex_dst, mem_dst, wb_dst);
            fwd_sel_b   = pick_src(id_srcb, id_useb, ex_fwd, mem_fwd, wb_fwd,
                                   ex_dst, mem_dst, wb_dst);
            stall_e     = hold_e;
            stall_m     = mem_stall;
            stall_f     = hold_e | load_use;
            stall_d     = hold_e | load_use;
            // A held EX keeps its own op, so the load-use bubble waits.
            bubble_e    = load_use & ~hold_e;
            bubble_w    = mem_stall;
            muldiv_busy = md_busy;
            muldiv_done = md_done;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;
    import common::*;
    import pipes::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    u1          id_valid, id_usea, id_useb;
    creg_addr_t id_srca, id_srcb;
    u1          ex_valid, ex_wen, ex_is_load, ex_is_muldiv;
    creg_addr_t ex_dst;
    u1          mem_valid, mem_wen, mem_req, mem_data_ok;
    creg_addr_t mem_dst;
    u1          wb_valid, wb_wen;
    creg_addr_t wb_dst;
    fwd_sel_t   fwd_sel_a, fwd_sel_b;
    u1          stall_f, stall_d, stall_e, stall_m, bubble_e, bubble_w;
    u1          muldiv_busy, muldiv_done;

    hazard_ctrl #(
        .MULDIV_LAT (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_usea      (id_usea),
        .id_useb      (id_useb),
        .id_srca      (id_srca),
        .id_srcb      (id_srcb),
        .ex_valid     (ex_valid),
        .ex_wen       (ex_wen),
        .ex_is_load   (ex_is_load),
        .ex_is_muldiv (ex_is_muldiv),
        .ex_dst       (ex_dst),
        .mem_valid    (mem_valid),
        .mem_wen      (mem_wen),
        .mem_req      (mem_req),
        .mem_data_ok  (mem_data_ok),
        .mem_dst      (mem_dst),
        .wb_valid     (wb_valid),
        .wb_wen       (wb_wen),
        .wb_dst       (wb_dst),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .bubble_e     (bubble_e),
        .bubble_w     (bubble_w),
        .muldiv_busy  (muldiv_busy),
        .muldiv_done  (muldiv_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: remaining mul/div cycles after the entry cycle, and whether
    // the op currently in EX has already produced its result.
    int md_left = 0;
    bit md_fin  = 0;

    function automatic int ref_fwd(input creg_addr_t src, input bit used);
        if (!used || src == 0) return 0;
        if (ex_valid && ex_wen && !ex_is_load && ex_dst == src) return 1;
        if (mem_valid && mem_wen && mem_dst == src) return 2;
        if (wb_valid && wb_wen && wb_dst == src) return 3;
        return 0;
    endfunction

    task automatic tick();
        bit ms, lu, hold, busy, done, se;
        @(negedge clk);
        ms   = mem_valid && mem_req && !mem_data_ok;
        lu   = id_valid && ex_valid && ex_wen && ex_is_load && ex_dst != 0 &&
               ((id_usea && id_srca == ex_dst) || (id_useb && id_srcb == ex_dst));
`ifdef HAZARD_MULDIV_EN
        busy = md_left > 0;
        done = md_left == 1;
        hold = ex_valid && ex_is_muldiv && !md_fin && !done;
`else
        busy = 0;
        done = 0;
        hold = 0;
`endif
        se = ms || hold;
        if (reset) begin
            check("fwd_a", fwd_sel_a, 0);
            check("fwd_b", fwd_sel_b, 0);
            check("stall_f", stall_f, 0);
            check("stall_d", stall_d, 0);
            check("stall_e", stall_e, 0);
            check("stall_m", stall_m, 0);
            check("bubble_e", bubble_e, 0);
            check("bubble_w", bubble_w, 0);
            check("md_busy", muldiv_busy, 0);
            check("md_done", muldiv_done, 0);
        end else begin
            check("fwd_a", fwd_sel_a, ref_fwd(id_srca, id_usea));
            check("fwd_b", fwd_sel_b, ref_fwd(id_srcb, id_useb));
            check("stall_f", stall_f, se || lu);
            check("stall_d", stall_d, se || lu);
            check("stall_e", stall_e, se);
            check("stall_m", stall_m, ms);
            check("bubble_e", bubble_e, lu && !se);
            check("bubble_w", bubble_w, ms);
            check("md_busy", muldiv_busy, busy);
            check("md_done", muldiv_done, done);
        end
        @(posedge clk);
        if (reset) begin
            md_left = 0;
            md_fin  = 0;
        end else begin
            bit fin_n;
            fin_n = md_fin;
            if (done) fin_n = 1;
            if (ex_valid && !se) fin_n = 0;
            if (md_left > 0) md_left--;
            else if (ex_valid && ex_is_muldiv && !md_fin) md_left = LAT - 1;
            md_fin = fin_n;
        end
        #1;
    endtask

    task automatic clear_inputs();
        {id_valid, id_usea, id_useb, ex_valid, ex_wen, ex_is_load, ex_is_muldiv} = '0;
        {mem_valid, mem_wen, mem_req, wb_valid, wb_wen} = '0;
        mem_data_ok = 1'b1;
        {id_srca, id_srcb, ex_dst, mem_dst, wb_dst} = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        tick();
        tick();
        reset = 1'b0;

        // Forwarding priority and x0.
        id_valid = 1; id_usea = 1; id_srca = 5;
        ex_valid = 1; ex_wen = 1; ex_dst = 5;
        mem_valid = 1; mem_wen = 1; mem_dst = 5;
        #1 check("dir_fwd_ex", fwd_sel_a, FWD_EX);
        tick();
        ex_dst = 6;
        #1 check("dir_fwd_mem", fwd_sel_a, FWD_MEM);
        tick();
        id_srca = 0; ex_dst = 0;
        #1 check("dir_fwd_x0", fwd_sel_a, FWD_NONE);
        tick();

        // Load-use then MEM forward.
        clear_inputs();
        id_valid = 1; id_useb = 1; id_srcb = 7;
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_dst = 7;
        #1 check("dir_lu_stall", {stall_f, stall_d, bubble_e}, 3'b111);
        tick();
        ex_valid = 0; ex_is_load = 0; mem_valid = 1; mem_wen = 1; mem_dst = 7;
        #1 check("dir_lu_fwd", fwd_sel_b, FWD_MEM);
        check("dir_lu_nostall", {stall_f, stall_d, bubble_e}, 3'b000);
        tick();

        // Mem wait of three cycles.
        clear_inputs();
        mem_valid = 1; mem_req = 1;
        for (int c = 0; c < 4; c++) begin
            mem_data_ok = (c == 3);
            #1 check("dir_memwait",
                     {stall_f, stall_d, stall_e, stall_m, bubble_w}, (c < 3) ? 5'h1f : 5'h0);
            tick();
        end

`ifdef HAZARD_MULDIV_EN
        // Plain mul/div occupancy.
        clear_inputs();
        ex_valid = 1; ex_is_muldiv = 1;
        for (int c = 0; c < 6; c++) begin
            if (c >= 4) ex_is_muldiv = 0;
            #1 check("dir_md_stall_e", stall_e, c < 3);
            check("dir_md_done", muldiv_done, c == 3);
            check("dir_md_busy", muldiv_busy, c >= 1 && c <= 3);
            tick();
        end

        // Mul/div finishing under a mem wait must not restart.
        clear_inputs();
        ex_valid = 1; ex_is_muldiv = 1; mem_valid = 1; mem_req = 1;
        for (int c = 0; c < 9; c++) begin
            mem_data_ok = !(c >= 2 && c <= 6);
            if (c == 8) ex_is_muldiv = 0;
            #1 check("dir_mdw_stall_e", stall_e, c <= 6);
            check("dir_mdw_done", muldiv_done, c == 3);
            check("dir_mdw_busy", muldiv_busy, c >= 1 && c <= 3);
            tick();
        end

        // Reset in the middle of BUSY.
        clear_inputs();
        ex_valid = 1; ex_is_muldiv = 1;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0; ex_valid = 0; ex_is_muldiv = 0;
        #1 check("dir_rst_busy", muldiv_busy, 0);
        check("dir_rst_done", muldiv_done, 0);
        tick();
`endif

        // Randomized traffic over a small register window to force matches.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(63) == 0);
            id_valid     = $urandom_range(3) != 0;
            id_usea      = $urandom_range(1);
            id_useb      = $urandom_range(1);
            id_srca      = creg_addr_t'($urandom_range(3));
            id_srcb      = creg_addr_t'($urandom_range(3));
            ex_valid     = $urandom_range(3) != 0;
            ex_wen       = $urandom_range(1);
            ex_is_load   = $urandom_range(2) == 0;
            ex_is_muldiv = $urandom_range(3) == 0;
            ex_dst       = creg_addr_t'($urandom_range(3));
            mem_valid    = $urandom_range(1);
            mem_wen      = $urandom_range(1);
            mem_req      = $urandom_range(1);
            mem_data_ok  = $urandom_range(2) != 0;
            mem_dst      = creg_addr_t'($urandom_range(3));
            wb_valid     = $urandom_range(1);
            wb_wen       = $urandom_range(1);
            wb_dst       = creg_addr_t'($urandom_range(3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
